gpio_core_param: RTL and testbench

// - Parametrised GPIO pin core: next generation of the 32-pin GPIO datapath behind gpio_reg_top.
// - Features: per-pin input sync, optional glitch filter, 4-mode interrupt detect, sticky W1C intr state.
// - Supports direct and masked output / output-enable updates.
// - Sits between the register file (reg2hw/hw2reg style strobes) and the pad ring (cio_*).

---
 rtl/gpio_core_param.sv | 142 ++++++++++++++
 tb/tb_gpio_core_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_core_param.sv
// rtl/gpio_core_param.sv - parametrised GPIO pin core (input sync/filter, interrupt detect, out/oe regs)
// Optional glitch filter stage is built only when GPIO_INPUT_FILTER_EN is defined.
module gpio_core_param #(
    parameter int NUM_PINS      = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_PINS-1:0] cio_gpio_i,
    output logic [NUM_PINS-1:0] cio_gpio_o,
    output logic [NUM_PINS-1:0] cio_gpio_en_o,
    input  logic                out_we,
    input  logic [NUM_PINS-1:0] out_wd,
    input  logic                out_mwe,
    input  logic [NUM_PINS-1:0] out_mask,
    input  logic [NUM_PINS-1:0] out_md,
    input  logic                oe_we,
    input  logic [NUM_PINS-1:0] oe_wd,
    input  logic                oe_mwe,
    input  logic [NUM_PINS-1:0] oe_mask,
    input  logic [NUM_PINS-1:0] oe_md,
    input  logic [NUM_PINS-1:0] filter_en,
    input  logic [NUM_PINS-1:0] en_rise,
    input  logic [NUM_PINS-1:0] en_fall,
    input  logic [NUM_PINS-1:0] en_hi,
    input  logic [NUM_PINS-1:0] en_lo,
    input  logic [NUM_PINS-1:0] intr_enable,
    input  logic                intr_clr_we,
    input  logic [NUM_PINS-1:0] intr_clr_wd,
    input  logic                intr_test_we,
    input  logic [NUM_PINS-1:0] intr_test_wd,
    output logic [NUM_PINS-1:0] data_in_o,
    output logic [NUM_PINS-1:0] intr_state_o,
    output logic [NUM_PINS-1:0] intr_o
);

    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;
    logic [NUM_PINS-1:0] sync_out;
    logic [NUM_PINS-1:0] data_in_d;
    logic [NUM_PINS-1:0] data_in_q;
    logic [NUM_PINS-1:0] prev_q;
    logic [NUM_PINS-1:0] intr_state_q;
    logic [NUM_PINS-1:0] out_q;
    logic [NUM_PINS-1:0] oe_q;
    logic [NUM_PINS-1:0] out_d;
    logic [NUM_PINS-1:0] oe_d;
    logic [NUM_PINS-1:0] rise;
    logic [NUM_PINS-1:0] fall;
    logic [NUM_PINS-1:0] intr_set;
    logic [NUM_PINS-1:0] intr_clr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cio_gpio_i};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_INPUT_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);
    // Compared against the pre-increment count, so the value is accepted once
    // the incremented count reaches FILTER_CYCLES-1 (FILTER_CYCLES stable samples).
    localparam logic [CW-1:0] CNT_HIT = CW'(FILTER_CYCLES - 2);

    logic [NUM_PINS-1:0][CW-1:0] flt_cnt_q;
    logic [NUM_PINS-1:0]         flt_cand_q;
    logic [NUM_PINS-1:0]         flt_val_q;

    // Counters run regardless of filter_en so switching modes introduces no artefacts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flt_cnt_q  <= '0;
            flt_cand_q <= '0;
            flt_val_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_PINS; i++) begin
                if (sync_out[i] != flt_cand_q[i]) begin
                    flt_cand_q[i] <= sync_out[i];
                    flt_cnt_q[i]  <= '0;
                end else if (flt_cnt_q[i] != CNT_MAX) begin
                    flt_cnt_q[i] <= flt_cnt_q[i] + CW'(1);
                    if (flt_cnt_q[i] == CNT_HIT) begin
                        flt_val_q[i] <= flt_cand_q[i];
                    end
                end
            end
        end
    end

    assign data_in_d = (filter_en & flt_val_q) | (~filter_en & sync_out);
`else
    logic unused_filter_en;
    assign unused_filter_en = ^filter_en;
    assign data_in_d        = sync_out;
`endif

    assign rise     = data_in_q & ~prev_q;
    assign fall     = ~data_in_q & prev_q;
    assign intr_set = (en_rise & rise) | (en_fall & fall) | (en_hi & data_in_q)
                    | (en_lo & ~data_in_q) | (intr_test_we ? intr_test_wd : '0);
    assign intr_clr = intr_clr_we ? intr_clr_wd : '0;

    // Direct write lands first; a same-cycle masked write then edits that result.
    always_comb begin
        out_d = out_we ? out_wd : out_q;
        oe_d  = oe_we ? oe_wd : oe_q;
        if (out_mwe) begin
            out_d = (out_d & ~out_mask) | (out_md & out_mask);
        end
        if (oe_mwe) begin
            oe_d = (oe_d & ~oe_mask) | (oe_md & oe_mask);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_in_q    <= '0;
            prev_q       <= '0;
            intr_state_q <= '0;
            out_q        <= '0;
            oe_q         <= '0;
        end else begin
            data_in_q    <= data_in_d;
            prev_q       <= data_in_q;
            intr_state_q <= (intr_state_q & ~intr_clr) | intr_set;
            out_q        <= out_d;
            oe_q         <= oe_d;
        end
    end

    assign data_in_o     = data_in_q;
    assign intr_state_o  = intr_state_q;
    assign intr_o        = intr_state_q & intr_enable;
    assign cio_gpio_o    = out_q;
    assign cio_gpio_en_o = oe_q;

endmodule

// File: tb/tb_gpio_core_param.sv
// tb/tb_gpio_core_param.sv - self-checking bench for gpio_core_param
module tb_gpio_core_param;

    localparam int NP   = 32;
    localparam int SYNC = 2;
    localparam int FILT = 16;
`ifdef GPIO_INPUT_FILTER_EN
    localparam bit HAS_FILT = 1'b1;
`else
    localparam bit HAS_FILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] pad;
    logic [NP-1:0] gpio_o, gpio_en_o;
    logic          out_we, out_mwe, oe_we, oe_mwe;
    logic [NP-1:0] out_wd, out_mask, out_md, oe_wd, oe_mask, oe_md;
    logic [NP-1:0] filter_en, en_rise, en_fall, en_hi, en_lo, intr_enable;
    logic          intr_clr_we, intr_test_we;
    logic [NP-1:0] intr_clr_wd, intr_test_wd;
    logic [NP-1:0] data_in, intr_state, intr;

    int n_vec = 0;
    int n_bad = 0;
    logic [NP-1:0] exp_q[$];
    string         tag_q[$];
    string         cur_tag;
    logic [NP-1:0] e;

    always #5 clk = ~clk;

    gpio_core_param #(.NUM_PINS(NP), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT)) dut (
        .clk_i(clk), .rst_i(rst), .cio_gpio_i(pad),
        .cio_gpio_o(gpio_o), .cio_gpio_en_o(gpio_en_o),
        .out_we(out_we), .out_wd(out_wd), .out_mwe(out_mwe), .out_mask(out_mask), .out_md(out_md),
        .oe_we(oe_we), .oe_wd(oe_wd), .oe_mwe(oe_mwe), .oe_mask(oe_mask), .oe_md(oe_md),
        .filter_en(filter_en), .en_rise(en_rise), .en_fall(en_fall), .en_hi(en_hi), .en_lo(en_lo),
        .intr_enable(intr_enable), .intr_clr_we(intr_clr_we), .intr_clr_wd(intr_clr_wd),
        .intr_test_we(intr_test_we), .intr_test_wd(intr_test_wd),
        .data_in_o(data_in), .intr_state_o(intr_state), .intr_o(intr)
    );

    task automatic push(input string t, input logic [NP-1:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    function automatic logic [NP-1:0] pop_exp();
        cur_tag = tag_q.pop_front();
        return exp_q.pop_front();
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pad = '0;
        out_we = 1'b1; out_wd = '1; out_mwe = 1'b0; out_mask = '0; out_md = '0;
        oe_we = 1'b1; oe_wd = '1; oe_mwe = 1'b0; oe_mask = '0; oe_md = '0;
        filter_en = '0; en_rise = '0; en_fall = '0; en_hi = '0; en_lo = '0;
        intr_enable = '1; intr_clr_we = 1'b0; intr_clr_wd = '0;
        intr_test_we = 1'b1; intr_test_wd = '1;
        push("rst_out", '0); push("rst_oe", '0); push("rst_intr", '0);
        push("rst_data_in", '0); push("rst_state", '0);
        step(3);
        e = pop_exp(); n_vec++; if (gpio_o !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, gpio_o, e); end
        e = pop_exp(); n_vec++; if (gpio_en_o !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, gpio_en_o, e); end
        e = pop_exp(); n_vec++; if (intr !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr, e); end
        e = pop_exp(); n_vec++; if (data_in !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, data_in, e); end
        e = pop_exp(); n_vec++; if (intr_state !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr_state, e); end
        out_we = 1'b0; out_wd = '0; oe_we = 1'b0; oe_wd = '0;
        intr_test_we = 1'b0; intr_test_wd = '0; intr_enable = '0;
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_latency();
        pad = 32'h1;
        push("lat_early", 32'h0); push("lat_exact", 32'h1); push("lat_no_intr", 32'h0);
        step(SYNC);
        e = pop_exp(); n_vec++; if (data_in !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, data_in, e); end
        step(1);
        e = pop_exp(); n_vec++; if (data_in !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, data_in, e); end
        step(2);
        e = pop_exp(); n_vec++; if (intr_state !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr_state, e); end
    endtask

    task automatic test_rise_w1c();
        en_rise = 32'h8; intr_enable = 32'h8;
        pad = pad | 32'h8;
        push("rise_state", 32'h8); push("rise_intr", 32'h8);
        step(SYNC + 3);
        e = pop_exp(); n_vec++; if (intr_state !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr_state, e); end
        e = pop_exp(); n_vec++; if (intr !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr, e); end
        intr_clr_we = 1'b1; intr_clr_wd = 32'h8;
        push("w1c_clear", 32'h0); push("w1c_stays", 32'h0); push("w1c_intr", 32'h0);
        step(1);
        intr_clr_we = 1'b0; intr_clr_wd = '0;
        e = pop_exp(); n_vec++; if (intr_state !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr_state, e); end
        step(4);
        e = pop_exp(); n_vec++; if (intr_state !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr_state, e); end
        e = pop_exp(); n_vec++; if (intr !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr, e); end
    endtask

    task automatic test_level_priority();
        en_hi = 32'h1;
        push("hi_set", 32'h1); push("hi_clr_set", 32'h1); push("hi_off_clr", 32'h0);
        step(2);
        e = pop_exp(); n_vec++; if (intr_state !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr_state, e); end
        intr_clr_we = 1'b1; intr_clr_wd = 32'h1;
        step(1);
        intr_clr_we = 1'b0; intr_clr_wd = '0;
        e = pop_exp(); n_vec++; if (intr_state !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr_state, e); end
        en_hi = '0; intr_clr_we = 1'b1; intr_clr_wd = 32'h1;
        step(1);
        intr_clr_we = 1'b0; intr_clr_wd = '0;
        e = pop_exp(); n_vec++; if (intr_state !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr_state, e); end
    endtask

    task automatic test_filter();
        logic seen;
        filter_en = 32'h20;
        step(FILT + 4);
        push("flt_pulse15", HAS_FILT ? 32'h0 : 32'h20);
        push("flt_hold16", 32'h20);
        pad[5] = 1'b1; step(FILT - 1); pad[5] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < FILT + 10; i++) begin step(1); seen = seen | data_in[5]; end
        e = pop_exp(); n_vec++; if (({26'b0, seen, 5'b0}) !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, {26'b0, seen, 5'b0}, e); end
        pad[5] = 1'b1; step(FILT); pad[5] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < FILT + 10; i++) begin step(1); seen = seen | data_in[5]; end
        e = pop_exp(); n_vec++; if (({26'b0, seen, 5'b0}) !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, {26'b0, seen, 5'b0}, e); end
    endtask

    task automatic test_out_regs();
        out_we = 1'b1; out_wd = 32'hFFFF_0000;
        push("out_not_yet", 32'h0); push("out_direct", 32'hFFFF_0000);
        e = pop_exp(); n_vec++; if (gpio_o !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, gpio_o, e); end
        step(1);
        out_we = 1'b0;
        e = pop_exp(); n_vec++; if (gpio_o !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, gpio_o, e); end
        out_mwe = 1'b1; out_mask = 32'h00FF; out_md = 32'h0055;
        push("out_masked", 32'hFFFF_0055);
        step(1);
        e = pop_exp(); n_vec++; if (gpio_o !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, gpio_o, e); end
        out_we = 1'b1; out_wd = 32'h0; out_mask = 32'hF; out_md = 32'hA;
        push("out_both", 32'h0000_000A);
        step(1);
        out_we = 1'b0; out_mwe = 1'b0;
        e = pop_exp(); n_vec++; if (gpio_o !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, gpio_o, e); end
        oe_we = 1'b1; oe_wd = 32'h1234_5678; oe_mwe = 1'b1; oe_mask = 32'hF0; oe_md = 32'hA0;
        push("oe_both", 32'h1234_56A8);
        step(1);
        oe_we = 1'b0; oe_mwe = 1'b0;
        e = pop_exp(); n_vec++; if (gpio_en_o !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, gpio_en_o, e); end
        oe_mwe = 1'b1; oe_mask = 32'hFFFF_0000; oe_md = 32'hBEEF_0000;
        push("oe_masked", 32'hBEEF_56A8);
        step(1);
        oe_mwe = 1'b0;
        e = pop_exp(); n_vec++; if (gpio_en_o !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, gpio_en_o, e); end
    endtask

    task automatic test_reset_mid_filter();
        int lat;
        lat = HAS_FILT ? SYNC + 1 + FILT : SYNC + 1;
        filter_en = 32'h20;
        pad[5] = 1'b1;
        step(SYNC + 8);
        rst = 1'b1;
        #1;
        push("mid_rst_out", '0); push("mid_rst_oe", '0); push("mid_rst_intr", '0); push("mid_rst_data", '0);
        e = pop_exp(); n_vec++; if (gpio_o !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, gpio_o, e); end
        e = pop_exp(); n_vec++; if (gpio_en_o !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, gpio_en_o, e); end
        e = pop_exp(); n_vec++; if (intr !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, intr, e); end
        e = pop_exp(); n_vec++; if (data_in !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, data_in, e); end
        step(2);
        rst = 1'b0;
        push("restart_early", 32'h0); push("restart_exact", 32'h20);
        step(lat - 1);
        e = pop_exp(); n_vec++; if ((data_in & 32'h20) !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, data_in & 32'h20, e); end
        step(1);
        e = pop_exp(); n_vec++; if ((data_in & 32'h20) !== e) begin n_bad++; $display("FAIL %s: got %h expected %h", cur_tag, data_in & 32'h20, e); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_rise_w1c();
        test_level_priority();
        test_filter();
        test_out_regs();
        test_reset_mid_filter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
